core2axi_ot: RTL and testbench

CORE2AXI_OT -- requirements
Module: core2axi_ot

---
 rtl/core2axi_ot_if.sv | 88 ++++++++
 rtl/core2axi_ot.sv | 187 ++++++++++++++++++
 tb/tb_core2axi_ot.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/core2axi_ot_if.sv
// AXI4 bus bundle (all five channels) shared by the core-to-AXI bridge and its environment.
interface AXI_BUS #(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter int unsigned AXI_ID_WIDTH   = 6,
    parameter int unsigned AXI_USER_WIDTH = 6
);
    localparam int unsigned AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;

    logic [AXI_ID_WIDTH-1:0]   aw_id;
    logic [AXI_ADDR_WIDTH-1:0] aw_addr;
    logic [7:0]                aw_len;
    logic [2:0]                aw_size;
    logic [1:0]                aw_burst;
    logic                      aw_lock;
    logic [3:0]                aw_cache;
    logic [2:0]                aw_prot;
    logic [3:0]                aw_region;
    logic [3:0]                aw_qos;
    logic [AXI_USER_WIDTH-1:0] aw_user;
    logic                      aw_valid;
    logic                      aw_ready;

    logic [AXI_DATA_WIDTH-1:0] w_data;
    logic [AXI_STRB_WIDTH-1:0] w_strb;
    logic                      w_last;
    logic [AXI_USER_WIDTH-1:0] w_user;
    logic                      w_valid;
    logic                      w_ready;

    logic [AXI_ID_WIDTH-1:0]   b_id;
    logic [1:0]                b_resp;
    logic [AXI_USER_WIDTH-1:0] b_user;
    logic                      b_valid;
    logic                      b_ready;

    logic [AXI_ID_WIDTH-1:0]   ar_id;
    logic [AXI_ADDR_WIDTH-1:0] ar_addr;
    logic [7:0]                ar_len;
    logic [2:0]                ar_size;
    logic [1:0]                ar_burst;
    logic                      ar_lock;
    logic [3:0]                ar_cache;
    logic [2:0]                ar_prot;
    logic [3:0]                ar_region;
    logic [3:0]                ar_qos;
    logic [AXI_USER_WIDTH-1:0] ar_user;
    logic                      ar_valid;
    logic                      ar_ready;

    logic [AXI_ID_WIDTH-1:0]   r_id;
    logic [AXI_DATA_WIDTH-1:0] r_data;
    logic [1:0]                r_resp;
    logic                      r_last;
    logic [AXI_USER_WIDTH-1:0] r_user;
    logic                      r_valid;
    logic                      r_ready;

    modport Master (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
               aw_region, aw_qos, aw_user, aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_last, w_user, w_valid,
        input  w_ready,
        input  b_id, b_resp, b_user, b_valid,
        output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
               ar_region, ar_qos, ar_user, ar_valid,
        input  ar_ready,
        input  r_id, r_data, r_resp, r_last, r_user, r_valid,
        output r_ready
    );

    modport Slave (
        input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
               aw_region, aw_qos, aw_user, aw_valid,
        output aw_ready,
        input  w_data, w_strb, w_last, w_user, w_valid,
        output w_ready,
        output b_id, b_resp, b_user, b_valid,
        input  b_ready,
        input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
               ar_region, ar_qos, ar_user, ar_valid,
        output ar_ready,
        output r_id, r_data, r_resp, r_last, r_user, r_valid,
        input  r_ready
    );
endinterface

// File: rtl/core2axi_ot.sv
// Core data port to AXI4 master bridge with up to MAX_OUTSTANDING single-beat transactions in flight.
// Optional error output data_err_o is enabled by defining CORE2AXI_OT_ERR_EN.
module core2axi_ot #(
    parameter int unsigned AXI_ADDR_WIDTH  = 32,
    parameter int unsigned AXI_DATA_WIDTH  = 32,
    parameter int unsigned AXI_ID_WIDTH    = 6,
    parameter int unsigned AXI_USER_WIDTH  = 6,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      data_req_i,
    output logic                      data_gnt_o,
    output logic                      data_rvalid_o,
    input  logic [AXI_ADDR_WIDTH-1:0] data_addr_i,
    input  logic                      data_we_i,
    input  logic [3:0]                data_be_i,
    input  logic [31:0]               data_wdata_i,
    output logic [31:0]               data_rdata_o,
`ifdef CORE2AXI_OT_ERR_EN
    output logic                      data_err_o,
`endif
    AXI_BUS.Master                    master
);

    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    typedef enum logic {
        DIR_READ  = 1'b0,
        DIR_WRITE = 1'b1
    } dir_e;

    logic [CNT_W-1:0] count_q, count_d;
    dir_e             dir_q, dir_d, req_dir;
    logic             aw_done_q, aw_done_d;
    logic             w_done_q, w_done_d;
    logic             rvalid_q;
    logic [31:0]      rdata_q, rdata_d;
    logic [31:0]      rd_data;

    logic eligible, ar_valid, aw_valid, w_valid;
    logic aw_fire, w_fire, rd_gnt, wr_gnt, gnt;
    logic r_hs, b_hs, rsp;

    always_comb begin
        req_dir   = data_we_i ? DIR_WRITE : DIR_READ;
        // Grant eligibility is based on the registered count, so a direction
        // change only proceeds once the drained state has been registered.
        eligible  = rst_ni && data_req_i && (count_q < CNT_W'(MAX_OUTSTANDING)) &&
                    ((count_q == '0) || (dir_q == req_dir));
        ar_valid  = eligible && !data_we_i;
        aw_valid  = eligible && data_we_i && !aw_done_q;
        w_valid   = eligible && data_we_i && !w_done_q;
        aw_fire   = aw_valid && master.aw_ready;
        w_fire    = w_valid && master.w_ready;
        rd_gnt    = ar_valid && master.ar_ready;
        wr_gnt    = eligible && data_we_i && (aw_done_q || aw_fire) && (w_done_q || w_fire);
        gnt       = rd_gnt || wr_gnt;

        aw_done_d = wr_gnt ? 1'b0 : (aw_done_q || aw_fire);
        w_done_d  = wr_gnt ? 1'b0 : (w_done_q || w_fire);

        r_hs      = (count_q != '0) && (dir_q == DIR_READ) && master.r_valid;
        b_hs      = (count_q != '0) && (dir_q == DIR_WRITE) && master.b_valid;
        rsp       = r_hs || b_hs;

        case ({gnt, rsp})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        dir_d     = gnt ? req_dir : dir_q;
        rdata_d   = r_hs ? rd_data : rdata_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q   <= '0;
            dir_q     <= DIR_READ;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            count_q   <= count_d;
            dir_q     <= dir_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            rvalid_q  <= rsp;
            rdata_q   <= rdata_d;
        end
    end

`ifdef CORE2AXI_OT_ERR_EN
    logic err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else begin
            err_q <= (r_hs && master.r_resp[1]) || (b_hs && master.b_resp[1]);
        end
    end

    assign data_err_o = err_q;

    logic unused_inputs;
    assign unused_inputs = ^{master.r_id, master.r_last, master.r_user, master.r_resp[0],
                             master.b_id, master.b_user, master.b_resp[0]};
`else
    logic unused_inputs;
    assign unused_inputs = ^{master.r_id, master.r_last, master.r_user, master.r_resp,
                             master.b_id, master.b_user, master.b_resp};
`endif

    generate
        if (AXI_DATA_WIDTH == 64) begin : g_wide
            // Read lane (addr[2]) recorded per read grant, consumed in order by R beats.
            logic [MAX_OUTSTANDING-1:0] lane_q;
            logic [PTR_W-1:0]           wr_ptr_q, rd_ptr_q;

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    lane_q   <= '0;
                    wr_ptr_q <= '0;
                    rd_ptr_q <= '0;
                end else begin
                    if (rd_gnt) begin
                        lane_q[wr_ptr_q] <= data_addr_i[2];
                        wr_ptr_q <= (wr_ptr_q == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr_q + 1'b1;
                    end
                    if (r_hs) begin
                        rd_ptr_q <= (rd_ptr_q == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr_q + 1'b1;
                    end
                end
            end

            assign rd_data       = lane_q[rd_ptr_q] ? master.r_data[63:32] : master.r_data[31:0];
            assign master.w_data = {data_wdata_i, data_wdata_i};
            assign master.w_strb = data_addr_i[2] ? {data_be_i, 4'b0000} : {4'b0000, data_be_i};
        end else begin : g_narrow
            assign rd_data       = master.r_data;
            assign master.w_data = data_wdata_i;
            assign master.w_strb = data_be_i;
        end
    endgenerate

    assign data_gnt_o       = gnt;
    assign data_rvalid_o    = rvalid_q;
    assign data_rdata_o     = rdata_q;

    assign master.aw_id     = {AXI_ID_WIDTH{1'b0}};
    assign master.aw_addr   = data_addr_i;
    assign master.aw_len    = '0;
    assign master.aw_size   = 3'b010;
    assign master.aw_burst  = 2'b01;
    assign master.aw_lock   = 1'b0;
    assign master.aw_cache  = '0;
    assign master.aw_prot   = '0;
    assign master.aw_region = '0;
    assign master.aw_qos    = '0;
    assign master.aw_user   = {AXI_USER_WIDTH{1'b0}};
    assign master.aw_valid  = aw_valid;

    assign master.w_last    = 1'b1;
    assign master.w_user    = {AXI_USER_WIDTH{1'b0}};
    assign master.w_valid   = w_valid;

    assign master.b_ready   = 1'b1;

    assign master.ar_id     = {AXI_ID_WIDTH{1'b0}};
    assign master.ar_addr   = data_addr_i;
    assign master.ar_len    = '0;
    assign master.ar_size   = 3'b010;
    assign master.ar_burst  = 2'b01;
    assign master.ar_lock   = 1'b0;
    assign master.ar_cache  = '0;
    assign master.ar_prot   = '0;
    assign master.ar_region = '0;
    assign master.ar_qos    = '0;
    assign master.ar_user   = {AXI_USER_WIDTH{1'b0}};
    assign master.ar_valid  = ar_valid;

    assign master.r_ready   = 1'b1;

endmodule

// File: tb/tb_core2axi_ot.sv
// Directed self-checking bench for core2axi_ot (64-bit data, MAX_OUTSTANDING=4).
module tb_core2axi_ot;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic        gnt;
    logic        rvalid;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
`ifdef CORE2AXI_OT_ERR_EN
    logic        err;
`endif

    int errors = 0;
    int checks = 0;

    AXI_BUS #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(64), .AXI_ID_WIDTH(6), .AXI_USER_WIDTH(6)) axi ();

    core2axi_ot #(
        .AXI_ADDR_WIDTH (32),
        .AXI_DATA_WIDTH (64),
        .AXI_ID_WIDTH   (6),
        .AXI_USER_WIDTH (6),
        .MAX_OUTSTANDING(4)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .data_req_i   (req),
        .data_gnt_o   (gnt),
        .data_rvalid_o(rvalid),
        .data_addr_i  (addr),
        .data_we_i    (we),
        .data_be_i    (be),
        .data_wdata_i (wdata),
        .data_rdata_o (rdata),
`ifdef CORE2AXI_OT_ERR_EN
        .data_err_o   (err),
`endif
        .master       (axi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b0; req = 1'b1; we = 1'b0; addr = 32'h0; axi.ar_ready = 1'b1;
        @(negedge clk); #1;
        checks++; if (axi.ar_valid !== 1'b0) begin errors++; $display("FAIL reset_ar_valid: got %b expected 0", axi.ar_valid); end
        checks++; if (gnt !== 1'b0) begin errors++; $display("FAIL reset_gnt: got %b expected 0", gnt); end
        checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b expected 0", rvalid); end
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
        checks++; if (dut.count_q !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", dut.count_q); end
        we = 1'b1; #1;
        checks++; if (axi.aw_valid !== 1'b0 || axi.w_valid !== 1'b0) begin errors++; $display("FAIL reset_aw_w_valid: got %b%b expected 00", axi.aw_valid, axi.w_valid); end
        checks++; if (axi.r_ready !== 1'b1 || axi.b_ready !== 1'b1) begin errors++; $display("FAIL ready_const: got r=%b b=%b expected 1 1", axi.r_ready, axi.b_ready); end
        checks++; if (axi.ar_size !== 3'd2 || axi.ar_burst !== 2'b01 || axi.ar_len !== 8'd0 || axi.ar_id !== 6'd0)
            begin errors++; $display("FAIL ar_const: got size=%0d burst=%b len=%0d id=%0d expected 2 01 0 0", axi.ar_size, axi.ar_burst, axi.ar_len, axi.ar_id); end
        checks++; if (axi.aw_size !== 3'd2 || axi.aw_burst !== 2'b01 || axi.w_last !== 1'b1 || axi.aw_cache !== 4'd0)
            begin errors++; $display("FAIL aw_w_const: got size=%0d burst=%b last=%b cache=%h expected 2 01 1 0", axi.aw_size, axi.aw_burst, axi.w_last, axi.aw_cache); end
        req = 1'b0; we = 1'b0; axi.ar_ready = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_read_throughput();
        logic exp_g;
        logic [31:0] exp_d;
        axi.ar_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            req = 1'b1; we = 1'b0; addr = 32'h200 + 32'(4 * i);
            #1;
            exp_g = (i < 4);
            checks++; if (gnt !== exp_g) begin errors++; $display("FAIL rd_gnt[%0d]: got %b expected %b", i, gnt, exp_g); end
            checks++; if (axi.ar_valid !== exp_g) begin errors++; $display("FAIL rd_ar_valid[%0d]: got %b expected %b", i, axi.ar_valid, exp_g); end
            if (exp_g) begin
                checks++; if (axi.ar_addr !== addr) begin errors++; $display("FAIL rd_ar_addr[%0d]: got %h expected %h", i, axi.ar_addr, addr); end
            end
        end
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            req = 1'b0;
            if (j == 0) begin
                #1;
                checks++; if (dut.count_q !== 3'd4) begin errors++; $display("FAIL rd_count_full: got %0d expected 4", dut.count_q); end
                checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL rd_early_rvalid: got %b expected 0", rvalid); end
            end else begin
                exp_d = ((j - 1) % 2 == 1) ? 32'hA000_0000 + 32'(j - 1) : 32'hB000_0000 + 32'(j - 1);
                #1;
                checks++; if (rvalid !== 1'b1) begin errors++; $display("FAIL rd_rvalid[%0d]: got %b expected 1", j - 1, rvalid); end
                checks++; if (rdata !== exp_d) begin errors++; $display("FAIL rd_rdata[%0d]: got %h expected %h", j - 1, rdata, exp_d); end
            end
            if (j < 4) begin
                axi.r_valid = 1'b1;
                axi.r_data  = {32'hA000_0000 + 32'(j), 32'hB000_0000 + 32'(j)};
            end else begin
                axi.r_valid = 1'b0;
            end
        end
        @(negedge clk); #1;
        checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL rd_rvalid_end: got %b expected 0", rvalid); end
        checks++; if (dut.count_q !== 3'd0) begin errors++; $display("FAIL rd_count_end: got %0d expected 0", dut.count_q); end
        axi.ar_ready = 1'b0;
    endtask

    task automatic test_write_split();
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 32'h104; be = 4'hF; wdata = 32'hDEAD_BEEF;
        axi.aw_ready = 1'b1; axi.w_ready = 1'b0;
        #1;
        checks++; if (axi.aw_valid !== 1'b1 || axi.w_valid !== 1'b1) begin errors++; $display("FAIL wr_valids_c0: got aw=%b w=%b expected 1 1", axi.aw_valid, axi.w_valid); end
        checks++; if (gnt !== 1'b0) begin errors++; $display("FAIL wr_gnt_c0: got %b expected 0", gnt); end
        checks++; if (axi.w_strb !== 8'hF0) begin errors++; $display("FAIL wr_strb: got %h expected f0", axi.w_strb); end
        checks++; if (axi.w_data !== 64'hDEAD_BEEF_DEAD_BEEF) begin errors++; $display("FAIL wr_data: got %h expected deadbeefdeadbeef", axi.w_data); end
        checks++; if (axi.aw_addr !== 32'h104) begin errors++; $display("FAIL wr_aw_addr: got %h expected 104", axi.aw_addr); end
        @(negedge clk);
        axi.aw_ready = 1'b0;
        #1;
        checks++; if (axi.aw_valid !== 1'b0 || axi.w_valid !== 1'b1 || gnt !== 1'b0)
            begin errors++; $display("FAIL wr_c1: got aw=%b w=%b gnt=%b expected 0 1 0", axi.aw_valid, axi.w_valid, gnt); end
        @(negedge clk);
        axi.w_ready = 1'b1;
        #1;
        checks++; if (axi.aw_valid !== 1'b0 || axi.w_valid !== 1'b1 || gnt !== 1'b1)
            begin errors++; $display("FAIL wr_c2: got aw=%b w=%b gnt=%b expected 0 1 1", axi.aw_valid, axi.w_valid, gnt); end
        @(negedge clk);
        req = 1'b0; axi.w_ready = 1'b0; axi.b_valid = 1'b1;
        #1;
        checks++; if (dut.count_q !== 3'd1 || rvalid !== 1'b0) begin errors++; $display("FAIL wr_c3: got count=%0d rvalid=%b expected 1 0", dut.count_q, rvalid); end
        @(negedge clk);
        axi.b_valid = 1'b0;
        #1;
        checks++; if (rvalid !== 1'b1 || dut.count_q !== 3'd0) begin errors++; $display("FAIL wr_bresp: got rvalid=%b count=%0d expected 1 0", rvalid, dut.count_q); end
        @(negedge clk); #1;
        checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL wr_rvalid_pulse: got %b expected 0", rvalid); end
    endtask

    task automatic test_dir_switch();
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = 32'h10; axi.ar_ready = 1'b1;
        #1;
        checks++; if (gnt !== 1'b1) begin errors++; $display("FAIL ds_rd_gnt: got %b expected 1", gnt); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            we = 1'b1; addr = 32'h20; be = 4'h3; wdata = 32'h1234_5678;
            axi.aw_ready = 1'b1; axi.w_ready = 1'b1;
            #1;
            checks++; if (axi.aw_valid !== 1'b0 || axi.w_valid !== 1'b0 || gnt !== 1'b0)
                begin errors++; $display("FAIL ds_hold[%0d]: got aw=%b w=%b gnt=%b expected 0 0 0", k, axi.aw_valid, axi.w_valid, gnt); end
        end
        @(negedge clk);
        axi.r_valid = 1'b1; axi.r_data = {32'hCCCC_0001, 32'hDDDD_0001};
        #1;
        checks++; if (axi.aw_valid !== 1'b0) begin errors++; $display("FAIL ds_aw_during_r: got %b expected 0", axi.aw_valid); end
        @(negedge clk);
        axi.r_valid = 1'b0;
        #1;
        checks++; if (rvalid !== 1'b1 || rdata !== 32'hDDDD_0001) begin errors++; $display("FAIL ds_rresp: got rvalid=%b rdata=%h expected 1 dddd0001", rvalid, rdata); end
        checks++; if (axi.aw_valid !== 1'b1 || axi.w_valid !== 1'b1 || gnt !== 1'b1)
            begin errors++; $display("FAIL ds_wr_go: got aw=%b w=%b gnt=%b expected 1 1 1", axi.aw_valid, axi.w_valid, gnt); end
        checks++; if (axi.w_strb !== 8'h03) begin errors++; $display("FAIL ds_strb: got %h expected 03", axi.w_strb); end
        @(negedge clk);
        req = 1'b0; axi.aw_ready = 1'b0; axi.w_ready = 1'b0; axi.b_valid = 1'b1;
        #1;
        checks++; if (dut.count_q !== 3'd1) begin errors++; $display("FAIL ds_wr_count: got %0d expected 1", dut.count_q); end
        @(negedge clk);
        axi.b_valid = 1'b0;
        #1;
        checks++; if (rvalid !== 1'b1 || dut.count_q !== 3'd0) begin errors++; $display("FAIL ds_bresp: got rvalid=%b count=%0d expected 1 0", rvalid, dut.count_q); end
        axi.ar_ready = 1'b0;
    endtask

    task automatic test_simul_grant_rsp();
        axi.ar_ready = 1'b1;
        @(negedge clk); req = 1'b1; we = 1'b0; addr = 32'h300;
        @(negedge clk); addr = 32'h304;
        @(negedge clk);
        addr = 32'h308; axi.r_valid = 1'b1; axi.r_data = {32'h1111_1111, 32'h2222_2222};
        #1;
        checks++; if (dut.count_q !== 3'd2 || gnt !== 1'b1) begin errors++; $display("FAIL sg_pre: got count=%0d gnt=%b expected 2 1", dut.count_q, gnt); end
        @(negedge clk);
        req = 1'b0; axi.r_data = {32'h3333_3333, 32'h4444_4444};
        #1;
        checks++; if (dut.count_q !== 3'd2) begin errors++; $display("FAIL sg_count: got %0d expected 2", dut.count_q); end
        checks++; if (rvalid !== 1'b1 || rdata !== 32'h2222_2222) begin errors++; $display("FAIL sg_r0: got rvalid=%b rdata=%h expected 1 22222222", rvalid, rdata); end
        @(negedge clk);
        axi.r_data = {32'h5555_5555, 32'h6666_6666};
        #1;
        checks++; if (rdata !== 32'h3333_3333 || dut.count_q !== 3'd1) begin errors++; $display("FAIL sg_r1: got rdata=%h count=%0d expected 33333333 1", rdata, dut.count_q); end
        @(negedge clk);
        axi.r_valid = 1'b0;
        #1;
        checks++; if (rdata !== 32'h6666_6666 || dut.count_q !== 3'd0) begin errors++; $display("FAIL sg_r2: got rdata=%h count=%0d expected 66666666 0", rdata, dut.count_q); end
        axi.ar_ready = 1'b0;
    endtask

    task automatic test_idle_beats();
        @(negedge clk);
        axi.r_valid = 1'b1; axi.b_valid = 1'b1; axi.r_data = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clk);
        axi.r_valid = 1'b0; axi.b_valid = 1'b0;
        #1;
        checks++; if (rvalid !== 1'b0 || dut.count_q !== 3'd0) begin errors++; $display("FAIL idle_beat: got rvalid=%b count=%0d expected 0 0", rvalid, dut.count_q); end
    endtask

`ifdef CORE2AXI_OT_ERR_EN
    task automatic test_err();
        axi.ar_ready = 1'b1;
        for (int e = 0; e < 2; e++) begin
            @(negedge clk); req = 1'b1; we = 1'b0; addr = 32'h40;
            @(negedge clk); req = 1'b0;
            axi.r_valid = 1'b1; axi.r_resp = (e == 0) ? 2'b10 : 2'b00; axi.r_data = 64'h0;
            @(negedge clk);
            axi.r_valid = 1'b0; axi.r_resp = 2'b00;
            #1;
            checks++; if (rvalid !== 1'b1 || err !== (e == 0)) begin errors++; $display("FAIL err[%0d]: got rvalid=%b err=%b expected 1 %b", e, rvalid, err, (e == 0)); end
        end
        axi.ar_ready = 1'b0;
    endtask
`endif

    task automatic test_reset_mid();
        axi.ar_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); req = 1'b1; we = 1'b0; addr = 32'h500 + 32'(4 * i);
        end
        @(negedge clk);
        axi.ar_ready = 1'b0;
        #1;
        checks++; if (dut.count_q !== 3'd3) begin errors++; $display("FAIL rm_count_pre: got %0d expected 3", dut.count_q); end
        rst_n = 1'b0;
        #1;
        checks++; if (axi.ar_valid !== 1'b0 || dut.count_q !== 3'd0) begin errors++; $display("FAIL rm_in_reset: got ar_valid=%b count=%0d expected 0 0", axi.ar_valid, dut.count_q); end
        we = 1'b1; #1;
        checks++; if (axi.aw_valid !== 1'b0 || axi.w_valid !== 1'b0 || gnt !== 1'b0)
            begin errors++; $display("FAIL rm_wr_valids: got aw=%b w=%b gnt=%b expected 0 0 0", axi.aw_valid, axi.w_valid, gnt); end
        @(negedge clk);
        req = 1'b0; we = 1'b0; rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            axi.r_valid = (c < 3);
            #1;
            checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL rm_spurious[%0d]: got %b expected 0", c, rvalid); end
        end
        axi.r_valid = 1'b0;
        @(negedge clk); #1;
        checks++; if (dut.count_q !== 3'd0) begin errors++; $display("FAIL rm_count_post: got %0d expected 0", dut.count_q); end
    endtask

    initial begin
        req = 1'b0; we = 1'b0; addr = '0; be = '0; wdata = '0; rst_n = 1'b0;
        axi.aw_ready = 1'b0; axi.w_ready = 1'b0; axi.ar_ready = 1'b0;
        axi.r_valid = 1'b0; axi.r_data = '0; axi.r_resp = '0; axi.r_last = 1'b1; axi.r_id = '0; axi.r_user = '0;
        axi.b_valid = 1'b0; axi.b_resp = '0; axi.b_id = '0; axi.b_user = '0;
        repeat (2) @(negedge clk);
        test_reset();
        test_read_throughput();
        test_write_split();
        test_dir_switch();
        test_simul_grant_rsp();
        test_idle_beats();
`ifdef CORE2AXI_OT_ERR_EN
        test_err();
`endif
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
